// File: rtl/render_pkg.sv
// Types and constants shared by the renderer blocks: line drawer state,
// coordinate width, and the op-codes the render controller already decodes.
package render_pkg;

    localparam int COORD_W = 10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } line_state_t;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_CLEAR = 4'h1;
    localparam logic [3:0] OP_LINE  = 4'h2;
    localparam logic [3:0] OP_FLUSH = 4'h3;

endpackage

// File: rtl/line_drawer_if.sv
// Controller-to-line-drawer bundle: endpoint load and step request in,
// registered pixel stream with done flag out.
interface line_drawer_if
    import render_pkg::*;
#(
    parameter int W = COORD_W
);
    logic         set_new;
    logic         draw_enable;
    logic [W-1:0] x0;
    logic [W-1:0] y0;
    logic [W-1:0] x1;
    logic [W-1:0] y1;
    logic [W-1:0] pix_x;
    logic [W-1:0] pix_y;
    logic         pix_valid;
    logic         done;

    modport master (
        output set_new, draw_enable, x0, y0, x1, y1,
        input  pix_x, pix_y, pix_valid, done
    );

    modport slave (
        input  set_new, draw_enable, x0, y0, x1, y1,
        output pix_x, pix_y, pix_valid, done
    );
endinterface

// File: rtl/bresenham_step.sv
// One combinational Bresenham iteration: given the error term and the current
// point, produce the next error term and point. Both axes may move together.
module bresenham_step
    import render_pkg::*;
#(
    parameter int W = COORD_W
) (
    input  logic signed [W+1:0] err,
    input  logic signed [W+1:0] dx,
    input  logic signed [W+1:0] dy,
    input  logic signed [1:0]   sx,
    input  logic signed [1:0]   sy,
    input  logic [W-1:0]        x,
    input  logic [W-1:0]        y,
    output logic signed [W+1:0] err_next,
    output logic [W-1:0]        x_next,
    output logic [W-1:0]        y_next
);
    logic signed [W+2:0] e2;
    logic signed [W+2:0] dx_ext;
    logic signed [W+2:0] dy_ext;
    logic                step_x;
    logic                step_y;

    always_comb begin
        e2     = $signed({err, 1'b0});
        dx_ext = $signed({dx[W+1], dx});
        dy_ext = $signed({dy[W+1], dy});
        step_x = (e2 >= dy_ext);
        step_y = (e2 <= dx_ext);

        err_next = err;
        if (step_x) begin
            err_next = err_next + dy;
        end
        if (step_y) begin
            err_next = err_next + dx;
        end

        // +/-1 step as modulo add; the point stays inside the endpoint box.
        x_next = step_x ? x + {{(W-2){sx[1]}}, sx} : x;
        y_next = step_y ? y + {{(W-2){sy[1]}}, sy} : y;
    end
endmodule

// File: rtl/line_drawer.sv
// Bresenham pixel generator: latches endpoints on set_new, emits one pixel per
// draw_enable, and flags done together with the far endpoint.
module line_drawer
    import render_pkg::*;
#(
    parameter int W = COORD_W
) (
    input  logic          clk,
    input  logic          rst,
    line_drawer_if.slave  bus
);
    line_state_t         state_q, state_d;
    logic signed [W+1:0] err_q, err_d;
    logic signed [W+1:0] dx_q, dx_d;
    logic signed [W+1:0] dy_q, dy_d;
    logic signed [1:0]   sx_q, sx_d;
    logic signed [1:0]   sy_q, sy_d;
    logic [W-1:0]        x_q, x_d;
    logic [W-1:0]        y_q, y_d;
    logic [W-1:0]        xe_q, xe_d;
    logic [W-1:0]        ye_q, ye_d;
    logic                valid_q, valid_d;
    logic                done_q, done_d;

    logic [W-1:0]        abs_x;
    logic [W-1:0]        abs_y;
    logic signed [W+1:0] err_step;
    logic [W-1:0]        x_step;
    logic [W-1:0]        y_step;

    assign abs_x = (bus.x1 >= bus.x0) ? bus.x1 - bus.x0 : bus.x0 - bus.x1;
    assign abs_y = (bus.y1 >= bus.y0) ? bus.y1 - bus.y0 : bus.y0 - bus.y1;

    bresenham_step #(.W(W)) u_step (
        .err      (err_q),
        .dx       (dx_q),
        .dy       (dy_q),
        .sx       (sx_q),
        .sy       (sy_q),
        .x        (x_q),
        .y        (y_q),
        .err_next (err_step),
        .x_next   (x_step),
        .y_next   (y_step)
    );

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        sx_d    = sx_q;
        sy_d    = sy_q;
        x_d     = x_q;
        y_d     = y_q;
        xe_d    = xe_q;
        ye_d    = ye_q;
        valid_d = 1'b0;
        done_d  = done_q;

        // A new line wins over stepping and discards any line in progress.
        if (bus.set_new) begin
            dx_d    = $signed({2'b00, abs_x});
            dy_d    = -$signed({2'b00, abs_y});
            err_d   = $signed({2'b00, abs_x}) - $signed({2'b00, abs_y});
            sx_d    = (bus.x1 >= bus.x0) ? 2'sd1 : -2'sd1;
            sy_d    = (bus.y1 >= bus.y0) ? 2'sd1 : -2'sd1;
            x_d     = bus.x0;
            y_d     = bus.y0;
            xe_d    = bus.x1;
            ye_d    = bus.y1;
            valid_d = bus.draw_enable;
            done_d  = (bus.x0 == bus.x1) && (bus.y0 == bus.y1);
            state_d = done_d ? DONE : ACTIVE;
        end else if (bus.draw_enable && state_q == ACTIVE) begin
            err_d   = err_step;
            x_d     = x_step;
            y_d     = y_step;
            valid_d = 1'b1;
            if (x_step == xe_q && y_step == ye_q) begin
                done_d  = 1'b1;
                state_d = DONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            err_q   <= '0;
            dx_q    <= '0;
            dy_q    <= '0;
            sx_q    <= '0;
            sy_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            xe_q    <= '0;
            ye_q    <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            x_q     <= x_d;
            y_q     <= y_d;
            xe_q    <= xe_d;
            ye_q    <= ye_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign bus.pix_x     = x_q;
    assign bus.pix_y     = y_q;
    assign bus.pix_valid = valid_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_line_drawer.sv
// Bench for line_drawer: a pixel-list model predicts outputs every cycle, and
// literal pixel tables pin the model for each directed line.
module tb_line_drawer;
    import render_pkg::*;

    localparam int W = COORD_W;

    typedef struct packed {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         d;
    } pix_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    line_drawer_if #(.W(W)) bus ();

    line_drawer #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks_total  = 0;
    int checks_passed = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks_total++;
        if (act == exp) begin
            checks_passed++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: on set_new the whole pixel list of the line is generated up front;
    // each accepted request then pops the next pixel.
    pix_t         m_q[$];
    logic [W-1:0] m_x = '0;
    logic [W-1:0] m_y = '0;
    logic         m_v = 1'b0;
    logic         m_d = 1'b0;
    bit           cmp_en = 1'b0;

    function automatic void build_line(input int ax0, input int ay0, input int ax1, input int ay1);
        int ddx, ddy, stx, sty, err, e2, px, py;
        pix_t p;
        m_q.delete();
        ddx = (ax1 > ax0) ? ax1 - ax0 : ax0 - ax1;
        ddy = -((ay1 > ay0) ? ay1 - ay0 : ay0 - ay1);
        stx = (ax1 >= ax0) ? 1 : -1;
        sty = (ay1 >= ay0) ? 1 : -1;
        err = ddx + ddy;
        px  = ax0;
        py  = ay0;
        forever begin
            p.x = px[W-1:0];
            p.y = py[W-1:0];
            p.d = (px == ax1 && py == ay1);
            m_q.push_back(p);
            if (p.d) break;
            e2 = 2 * err;
            if (e2 >= ddy) begin err += ddy; px += stx; end
            if (e2 <= ddx) begin err += ddx; py += sty; end
        end
    endfunction

    always @(posedge clk) begin
        pix_t p;
        if (rst) begin
            m_q.delete();
            m_x = '0; m_y = '0; m_v = 1'b0; m_d = 1'b0;
        end else if (bus.set_new) begin
            build_line(int'(bus.x0), int'(bus.y0), int'(bus.x1), int'(bus.y1));
            p = m_q.pop_front();
            m_x = p.x; m_y = p.y; m_d = p.d; m_v = bus.draw_enable;
        end else if (bus.draw_enable && m_q.size() > 0) begin
            p = m_q.pop_front();
            m_x = p.x; m_y = p.y; m_d = p.d; m_v = 1'b1;
        end else begin
            m_v = 1'b0;
        end
    end

    pix_t cap_q[$];
    pix_t lit_q[$];

    always @(negedge clk) begin
        pix_t p;
        if (cmp_en) begin
            check("cycle_outputs", {bus.pix_x, bus.pix_y, bus.pix_valid, bus.done},
                  {m_x, m_y, m_v, m_d});
            if (bus.pix_valid) begin
                p.x = bus.pix_x; p.y = bus.pix_y; p.d = bus.done;
                cap_q.push_back(p);
                $display("pix (%0d,%0d) done=%0b t=%0t", bus.pix_x, bus.pix_y, bus.done, $time);
            end
        end
    end

    task automatic drive(input bit se, input bit de,
                         input int a = 0, input int b = 0, input int c = 0, input int d = 0);
        bus.set_new     = se;
        bus.draw_enable = de;
        bus.x0 = a[W-1:0]; bus.y0 = b[W-1:0];
        bus.x1 = c[W-1:0]; bus.y1 = d[W-1:0];
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input int x, input int y, input bit d);
        pix_t p;
        p.x = x[W-1:0]; p.y = y[W-1:0]; p.d = d;
        lit_q.push_back(p);
    endtask

    task automatic check_lit(input string name);
        int n;
        check({name, "_count"}, cap_q.size(), lit_q.size());
        n = (cap_q.size() < lit_q.size()) ? cap_q.size() : lit_q.size();
        for (int i = 0; i < n; i++) begin
            check({name, "_pixel"}, cap_q[i], lit_q[i]);
        end
        cap_q.delete();
        lit_q.delete();
    endtask

    initial begin
        bus.set_new = 1'b0; bus.draw_enable = 1'b0;
        bus.x0 = '0; bus.y0 = '0; bus.x1 = '0; bus.y1 = '0;
        rst = 1'b1;
        drive(0, 0);
        cmp_en = 1'b1;
        drive(0, 0);
        rst = 1'b0;

        // Reset mid-line
        drive(1, 1, 0, 0, 9, 0);
        drive(0, 1);
        rst = 1'b1;
        drive(0, 1);
        drive(0, 1);
        rst = 1'b0;
        check("reset_outputs", {bus.pix_x, bus.pix_y, bus.pix_valid, bus.done}, 0);
        repeat (3) drive(0, 1);
        drive(0, 0);
        lit(0, 0, 0); lit(1, 0, 0);
        check_lit("reset");

        // Horizontal line, draw_enable every 4 cycles
        drive(1, 1, 2, 5, 6, 5);
        repeat (4) begin
            repeat (3) drive(0, 0);
            drive(0, 1);
        end
        drive(0, 1);
        drive(0, 0);
        check("horiz_done_hold", bus.done, 1);
        lit(2, 5, 0); lit(3, 5, 0); lit(4, 5, 0); lit(5, 5, 0); lit(6, 5, 1);
        check_lit("horiz");

        // Steep, negative-x line
        drive(1, 1, 3, 3, 1, 8);
        repeat (5) drive(0, 1);
        drive(0, 0);
        lit(3, 3, 0); lit(3, 4, 0); lit(2, 5, 0); lit(2, 6, 0); lit(1, 7, 0); lit(1, 8, 1);
        check_lit("steep");

        // Single point
        drive(1, 1, 7, 7, 7, 7);
        drive(0, 1);
        drive(0, 1);
        drive(0, 0);
        lit(7, 7, 1);
        check_lit("single");

        // Restart mid-line
        drive(1, 1, 0, 0, 9, 0);
        repeat (3) drive(0, 1);
        drive(1, 1, 5, 5, 5, 7);
        drive(0, 1);
        drive(0, 1);
        drive(0, 0);
        lit(0, 0, 0); lit(1, 0, 0); lit(2, 0, 0); lit(3, 0, 0);
        lit(5, 5, 0); lit(5, 6, 0); lit(5, 7, 1);
        check_lit("restart");

        // Back-to-back draw_enable
        drive(1, 1, 0, 0, 3, 3);
        repeat (3) drive(0, 1);
        drive(0, 1);
        check("b2b_fifth_valid", bus.pix_valid, 0);
        check("b2b_fifth_done", bus.done, 1);
        drive(0, 0);
        lit(0, 0, 0); lit(1, 1, 0); lit(2, 2, 0); lit(3, 3, 1);
        check_lit("b2b");

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end
endmodule
